// File: rtl/biu_x86.sv
// Bus interface unit: byte/word loads and stores at segment:offset over an 8- or 16-bit
// external bus, sequenced as one or two beats with configurable wait states.
module biu_x86 #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req,
  input  logic                         we,
  input  logic                         word,
  input  logic                         sext,
  input  logic [15:0]                  seg,
  input  logic [15:0]                  off,
  input  logic [15:0]                  wdata,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  rdata,
  output logic [19-$clog2(DATA_W/8):0] address,
  output logic [DATA_W/8-1:0]          be,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            out,
  output logic                         wren
);

  localparam int unsigned AW = 20 - $clog2(DATA_W / 8);
  localparam int unsigned BW = DATA_W / 8;
  localparam logic [2:0] LastWait = 3'(WAIT_STATES);

  if (!(DATA_W == 8 || DATA_W == 16)) begin : g_bad_width
    $error("biu_x86: DATA_W must be 8 or 16");
  end
  if (WAIT_STATES > 7) begin : g_bad_wait
    $error("biu_x86: WAIT_STATES must be 0..7");
  end

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_we, r_word, r_sext, r_two;
  logic [15:0] r_wdata, r_rdata;
  logic [19:0] r_ea0, r_ea1;
  logic [2:0]  r_wcnt;
  logic [7:0]  r_lo;

  logic        w_accept, w_beat_end, w_last_beat, w_full, w_lane;
  logic [19:0] w_ea_in0, w_ea_in1, w_ea;
  logic [15:0] w_din16, w_out16, w_load_val;
  logic [7:0]  w_out_byte, w_lane_byte;
  logic [1:0]  w_be2;

  // The second byte wraps within the segment: offset increments modulo 2^16.
  assign w_ea_in0 = {seg, 4'h0} + {4'h0, off};
  assign w_ea_in1 = {seg, 4'h0} + {4'h0, off + 16'd1};

  assign w_accept    = req && (r_state == StIdle || r_state == StDone);
  assign w_beat_end  = (r_wcnt == LastWait);
  assign w_last_beat = (r_state == StBeat1) || !r_two;
  assign w_ea        = (r_state == StBeat1) ? r_ea1 : r_ea0;
  assign w_full      = (DATA_W == 16) && r_word && !r_two;
  assign w_lane      = (DATA_W == 16) && w_ea[0];
  assign w_out_byte  = (r_state == StBeat1) ? r_wdata[15:8] : r_wdata[7:0];
  assign w_din16     = 16'(data_in);
  assign w_lane_byte = w_lane ? w_din16[15:8] : w_din16[7:0];
  assign w_be2       = w_full ? 2'b11 : (w_lane ? 2'b10 : 2'b01);
  assign w_out16     = w_full ? r_wdata : (w_lane ? {w_out_byte, 8'h00} : {8'h00, w_out_byte});

  always_comb begin
    w_load_val = {(r_sext ? {8{w_lane_byte[7]}} : 8'h00), w_lane_byte};
    if (r_word) w_load_val = w_full ? w_din16 : {w_lane_byte, r_lo};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: w_state_next = w_accept ? StBeat0 : StIdle;
      StBeat0:        if (w_beat_end) w_state_next = r_two ? StBeat1 : StDone;
      StBeat1:        if (w_beat_end) w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy    = (r_state == StBeat0) || (r_state == StBeat1);
    done    = (r_state == StDone);
    address = '0;
    be      = '0;
    out     = '0;
    wren    = 1'b0;
    if (busy) begin
      address = w_ea[19 -: AW];
      be      = w_be2[BW-1:0];
      wren    = r_we;
      if (r_we) out = w_out16[DATA_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_word  <= 1'b0;
      r_sext  <= 1'b0;
      r_two   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ea0   <= '0;
      r_ea1   <= '0;
      r_wcnt  <= '0;
      r_lo    <= '0;
    end else if (w_accept) begin
      r_we    <= we;
      r_word  <= word;
      r_sext  <= sext;
      r_wdata <= wdata;
      r_ea0   <= w_ea_in0;
      r_ea1   <= w_ea_in1;
      r_two   <= word && ((DATA_W == 8) || w_ea_in0[0] || (off == 16'hFFFF));
      r_wcnt  <= '0;
    end else if (busy) begin
      if (!w_beat_end) begin
        r_wcnt <= r_wcnt + 3'd1;
      end else begin
        r_wcnt <= '0;
        if (!r_we) begin
          if (w_last_beat) r_rdata <= w_load_val;
          else             r_lo    <= w_lane_byte;
        end
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_biu_x86.sv
// Bench for biu_x86: an 8-bit/0-wait and a 16-bit/2-wait instance against a beat-plan and
// byte-memory reference model, with directed cases and randomized traffic.
module tb_biu_x86;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req8, req16, we, word, sext;
  logic [15:0] seg, off, wdata;

  logic        busy8, done8, wren8;
  logic [15:0] rdata8;
  logic [19:0] address8;
  logic [0:0]  be8;
  logic [7:0]  data_in8, out8;

  logic        busy16, done16, wren16;
  logic [15:0] rdata16;
  logic [18:0] address16;
  logic [1:0]  be16;
  logic [15:0] data_in16, out16;

  always #5 clock = ~clock;

  biu_x86 #(.DATA_W(8), .WAIT_STATES(0)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .req(req8), .we(we), .word(word), .sext(sext),
    .seg(seg), .off(off), .wdata(wdata), .busy(busy8), .done(done8), .rdata(rdata8),
    .address(address8), .be(be8), .data_in(data_in8), .out(out8), .wren(wren8)
  );

  biu_x86 #(.DATA_W(16), .WAIT_STATES(2)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .req(req16), .we(we), .word(word), .sext(sext),
    .seg(seg), .off(off), .wdata(wdata), .busy(busy16), .done(done16), .rdata(rdata16),
    .address(address16), .be(be16), .data_in(data_in16), .out(out16), .wren(wren16)
  );

  // Bus-side memories (written by the DUTs) and model memories (written by the model).
  logic [7:0] dev8 [int];
  logic [7:0] dev16 [int];
  logic [7:0] ref8 [int];
  logic [7:0] ref16 [int];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_rd [2];

  function automatic logic [7:0] dflt(input int a);
    return 8'((a * 37) ^ (a >> 5) ^ 32'h5A);
  endfunction

  function automatic logic [7:0] rdm(input int m, input int a);
    case (m)
      0:       return dev8.exists(a) ? dev8[a] : dflt(a);
      1:       return dev16.exists(a) ? dev16[a] : dflt(a);
      2:       return ref8.exists(a) ? ref8[a] : dflt(a);
      default: return ref16.exists(a) ? ref16[a] : dflt(a);
    endcase
  endfunction

  task automatic wrm(input int m, input int a, input logic [7:0] v);
    case (m)
      0:       dev8[a] = v;
      1:       dev16[a] = v;
      2:       ref8[a] = v;
      default: ref16[a] = v;
    endcase
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory device: commits the current cycle's store lanes and presents read data.
  task automatic bus_serve();
    if (wren8) wrm(0, int'(address8), out8);
    if (wren16) begin
      if (be16[0]) wrm(1, int'({address16, 1'b0}), out16[7:0]);
      if (be16[1]) wrm(1, int'({address16, 1'b1}), out16[15:8]);
    end
    data_in8  = rdm(0, int'(address8));
    data_in16 = {rdm(1, int'({address16, 1'b1})), rdm(1, int'({address16, 1'b0}))};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    bus_serve();
  endtask

  task automatic sample(input bit sel, output logic [19:0] a, output logic [1:0] b,
                        output logic [15:0] o, output logic bz, output logic dn,
                        output logic wr, output logic [15:0] rd);
    if (sel) begin
      a = 20'(address16); b = be16; o = out16; bz = busy16; dn = done16; wr = wren16;
      rd = rdata16;
    end else begin
      a = address8; b = 2'(be8); o = 16'(out8); bz = busy8; dn = done8; wr = wren8;
      rd = rdata8;
    end
  endtask

  task automatic idle();
    req8 = 1'b0;
    req16 = 1'b0;
    step();
    chk("idle_busy8", 20'(busy8), 20'h0);
    chk("idle_done8", 20'(done8), 20'h0);
    chk("idle_busy16", 20'(busy16), 20'h0);
    chk("idle_done16", 20'(done16), 20'h0);
  endtask

  // One transaction. Entered while the target DUT is idle or in its done cycle; returns in
  // the done cycle so the next call is back-to-back. noise asserts req/garbage while busy.
  task automatic xfer(input bit sel, input bit t_we, input bit t_word, input bit t_sext,
                      input logic [15:0] t_seg, input logic [15:0] t_off,
                      input logic [15:0] t_wd, input bit noise);
    int ea, ea2, nb, ws;
    logic [19:0] ba [2];
    logic [1:0]  bb [2];
    logic [15:0] bo [2];
    logic [7:0]  lo, hi;
    logic [19:0] a;
    logic [1:0]  b;
    logic [15:0] o, rd;
    logic        bz, dn, wr;
    ea  = ((int'(t_seg) << 4) + int'(t_off)) & 32'hFFFFF;
    ea2 = ((int'(t_seg) << 4) + ((int'(t_off) + 1) & 32'hFFFF)) & 32'hFFFFF;
    ws  = sel ? 2 : 0;
    nb  = t_word ? 2 : 1;
    if (!sel) begin
      ba[0] = 20'(ea); ba[1] = 20'(ea2); bb[0] = 2'd1; bb[1] = 2'd1;
      bo[0] = {8'h00, t_wd[7:0]}; bo[1] = {8'h00, t_wd[15:8]};
    end else if (t_word && (ea % 2 == 0) && t_off != 16'hFFFF) begin
      nb = 1; ba[0] = 20'(ea / 2); bb[0] = 2'd3; bo[0] = t_wd;
      ba[1] = '0; bb[1] = '0; bo[1] = '0;
    end else begin
      ba[0] = 20'(ea / 2); ba[1] = 20'(ea2 / 2);
      bb[0] = (ea % 2 == 1) ? 2'd2 : 2'd1;
      bb[1] = (ea2 % 2 == 1) ? 2'd2 : 2'd1;
      bo[0] = (ea % 2 == 1) ? {t_wd[7:0], 8'h00} : {8'h00, t_wd[7:0]};
      bo[1] = (ea2 % 2 == 1) ? {t_wd[15:8], 8'h00} : {8'h00, t_wd[15:8]};
    end
    if (t_we) begin
      wrm(sel ? 3 : 2, ea, t_wd[7:0]);
      if (t_word) wrm(sel ? 3 : 2, ea2, t_wd[15:8]);
    end else begin
      lo = rdm(sel ? 3 : 2, ea);
      hi = t_word ? rdm(sel ? 3 : 2, ea2) : (t_sext ? {8{lo[7]}} : 8'h00);
      exp_rd[sel] = {hi, lo};
    end
    we = t_we; word = t_word; sext = t_sext; seg = t_seg; off = t_off; wdata = t_wd;
    req8 = !sel; req16 = sel;
    step();
    for (int bt = 0; bt < nb; bt++) begin
      for (int c = 0; c <= ws; c++) begin
        sample(sel, a, b, o, bz, dn, wr, rd);
        chk("beat_busy", 20'(bz), 20'h1);
        chk("beat_done", 20'(dn), 20'h0);
        chk("beat_addr", a, ba[bt]);
        chk("beat_be", 20'(b), 20'(bb[bt]));
        chk("beat_wren", 20'(wr), 20'(t_we));
        if (t_we) chk("beat_out", 20'(o), 20'(bo[bt]));
        if (noise) begin
          req8 = !sel; req16 = sel;
          we = 1'($urandom); word = 1'($urandom); seg = 16'($urandom);
          off = 16'($urandom); wdata = 16'($urandom);
        end else begin
          req8 = 1'b0; req16 = 1'b0;
        end
        step();
      end
    end
    req8 = 1'b0;
    req16 = 1'b0;
    sample(sel, a, b, o, bz, dn, wr, rd);
    chk("done_pulse", 20'(dn), 20'h1);
    chk("done_busy", 20'(bz), 20'h0);
    chk("done_be", 20'(b), 20'h0);
    chk("done_wren", 20'(wr), 20'h0);
    chk("done_rdata", 20'(rd), 20'(exp_rd[sel]));
  endtask

  initial begin
    logic [15:0] r_seg, r_off;
    reset_n = 1'b0;
    req8 = 1'b0; req16 = 1'b0; we = 1'b0; word = 1'b0; sext = 1'b0;
    seg = '0; off = '0; wdata = '0; data_in8 = '0; data_in16 = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    #12;
    chk("rst_addr8", address8, 20'h0);
    chk("rst_out8", 20'(out8), 20'h0);
    chk("rst_be8", 20'(be8), 20'h0);
    chk("rst_wren8", 20'(wren8), 20'h0);
    chk("rst_busy8", 20'(busy8), 20'h0);
    chk("rst_done8", 20'(done8), 20'h0);
    chk("rst_rdata8", 20'(rdata8), 20'h0);
    chk("rst_addr16", 20'(address16), 20'h0);
    chk("rst_be16", 20'(be16), 20'h0);
    chk("rst_rdata16", 20'(rdata16), 20'h0);
    @(negedge clock);
    reset_n = 1'b1;
    idle();

    // 8-bit bus: preload 0x1234 at 1234:0010, then read it back as a word.
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0010, 16'h1234, 1'b0);
    idle();
    xfer(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0010, 16'h0000, 1'b0);
    idle();
    // Segment wrap of the second byte, then physical wrap of a sign-extended byte load.
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 16'h2000, 16'hFFFF, 16'hBEEF, 1'b0);
    xfer(1'b0, 1'b0, 1'b1, 1'b0, 16'h2000, 16'hFFFF, 16'h0000, 1'b0);
    xfer(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h0080, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0015, 16'h0000, 1'b0);
    idle();

    // 16-bit bus, two wait states: aligned word load, odd word store, req noise while busy.
    xfer(1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0100, 16'h0000, 1'b1);
    idle();
    xfer(1'b1, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h0101, 16'hA55A, 1'b1);
    idle();
    xfer(1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0101, 16'h0000, 1'b0);
    xfer(1'b1, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0102, 16'h0000, 1'b0);
    idle();

    // Reset during beat1 of a store: outputs drop at once, no done, beat0 byte remains.
    we = 1'b1; word = 1'b1; sext = 1'b0; seg = 16'h4000; off = 16'h0033; wdata = 16'hC3D2;
    req16 = 1'b1;
    step();
    req16 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_b0_addr", 20'(address16), 20'h20019);
      chk("rst_b0_be", 20'(be16), 20'h2);
      if (c < 2) step();
    end
    @(posedge clock);
    #1;
    chk("rst_b1_be", 20'(be16), 20'h1);
    chk("rst_b1_wren", 20'(wren16), 20'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wren", 20'(wren16), 20'h0);
    chk("rst_mid_be", 20'(be16), 20'h0);
    chk("rst_mid_busy", 20'(busy16), 20'h0);
    chk("rst_mid_done", 20'(done16), 20'h0);
    chk("rst_mid_rdata", 20'(rdata16), 20'h0);
    chk("rst_mid_rdata8", 20'(rdata8), 20'h0);
    wrm(3, 32'h40033, 8'hD2);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    xfer(1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h0033, 16'h0000, 1'b0);
    idle();

    // Randomized traffic on both buses, mixing idle gaps and back-to-back requests.
    for (int i = 0; i < 80; i++) begin
      r_seg = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       r_off = 16'hFFFF;
        1:       r_off = 16'($urandom) & 16'hFFFE;
        default: r_off = 16'($urandom);
      endcase
      xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), r_seg, r_off,
           16'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/biu_x86.md
Name: biu_x86

Overview:
- Parametrised bus interface unit serving the x86 core's memory accesses: byte or word loads/stores addressed as segment:offset.
- Generalises the core's hard-wired 8-bit byte-serial bus to an 8- or 16-bit external data bus, with byte enables, configurable wait states and x86 real-mode wrap rules.
- Core issues one request, waits for a done pulse; BIU sequences one or two bus beats.

Parameters:
DATA_W, 8, external data bus width; legal values 8 or 16.
WAIT_STATES, 0, extra cycles each beat holds the address before read data is sampled (0..7).

Ports:
clock      in   1       system clock, rising edge
reset_n    in   1       asynchronous active-low reset
req        in   1       start request; sampled only when busy=0
we         in   1       1 = store, 0 = load
word       in   1       1 = 16-bit access, 0 = 8-bit access
sext       in   1       byte load only: sign-extend into rdata[15:8]
seg        in   16      segment
off        in   16      offset
wdata      in   16      store data; byte store uses wdata[7:0]
busy       out  1       transfer in progress; req ignored
done       out  1       one-cycle pulse, transfer complete
rdata      out  16      load result, valid in the done cycle and held until next load completes
address    out  20-log2(DATA_W/8)   physical byte address (DATA_W=8) or word address (DATA_W=16)
be         out  DATA_W/8  byte-lane enables for the current beat
data_in    in   DATA_W  memory read data
out        out  DATA_W  memory write data
wren       out  1       write strobe, high for every cycle of a store beat

Behaviour:
- Reset (async, immediate): address=0, out=0, be=0, wren=0, busy=0, done=0, rdata=0, state IDLE. Reset mid-transfer aborts: no done pulse, partial store not retried.
- Physical address ea = (seg<<4) + off, modulo 2^20; 0xFFFF:0x0010 -> 0x00000.
- Second byte of a word uses off2 = (off+1) mod 2^16 within the same segment, ea2 = (seg<<4)+off2 mod 2^20. It is never ea+1 when off=0xFFFF.
- Beat plan:
  - DATA_W=8: byte = 1 beat at ea. Word = beat0 low byte at ea, beat1 high byte at ea2.
  - DATA_W=16, byte: 1 beat, address=ea[19:1]. Lane is be=01 if ea[0]=0, else be=10.
  - DATA_W=16, word with ea[0]=0 and off!=0xFFFF: 1 beat, be=11.
  - DATA_W=16, other words: 2 beats. Beat0 uses the lane of ea; beat1 uses the lane of ea2.
- States: IDLE -> BEAT0 -> (BEAT1) -> DONE -> IDLE.
  - IDLE: busy=0, be=0, wren=0.
  - On an edge with req=1 in IDLE or DONE, all inputs are latched and the state becomes BEAT0. The core may change inputs afterwards.
  - Each beat lasts 1+WAIT_STATES cycles. address, be and (for stores) out and wren are stable for the whole beat.
  - Load data is sampled from the enabled lane(s) of data_in at the edge that ends the beat.
  - DONE lasts 1 cycle: done=1, busy=0, wren=0, be=0, rdata updated. A req in the DONE cycle is accepted (back-to-back). Otherwise the state returns to IDLE.
- Store lanes: the byte destined for lane k is driven on out[8k+7:8k]. Non-enabled lanes are driven 0.
- Load assembly: rdata = {hi, lo}.
  - Byte load: hi = sext ? {8{lo[7]}} : 8'h00.
  - Store completion leaves rdata unchanged.
- Latency (req edge to done cycle): 1 + beats*(1+WAIT_STATES) cycles.
  - WAIT_STATES=0 examples: byte = 2 cycles; 8-bit-bus word = 3 cycles; aligned 16-bit-bus word = 2 cycles.
- busy=1 in BEAT0/BEAT1. req while busy has no effect and is not queued.
- Illegal DATA_W values: elaboration error.

Test Plan:
- DATA_W=8, WAIT_STATES=0, load word seg=0x1234 off=0x0010 (mem[0x12350]=0x34, mem[0x12351]=0x12):
  - address 0x12350 then 0x12351; done 3 cycles after req; rdata=0x1234.
- DATA_W=8, store word seg=0x2000 off=0xFFFF wdata=0xBEEF:
  - beat0 address 0x2FFFF out=0xEF wren=1; beat1 address 0x20000 out=0xBE (segment wrap, not 0x30000).
- Physical wrap, load byte seg=0xFFFF off=0x0015 sext=1, mem[0x00005]=0x80:
  - address 0x00005; rdata=0xFF80.
- DATA_W=16, WAIT_STATES=2:
  - Aligned word load off=0x0100: single beat, be=11, address held 3 cycles, done 4 cycles after req.
  - Odd word store off=0x0101 wdata=0xA55A: two beats, be=10 out=0x5A00, then be=01 out=0x00A5.
- Back-to-back: second req asserted in the first transfer's done cycle -> accepted, BEAT0 begins next cycle, no idle gap.
- req while busy=1 is ignored (exactly one done per accepted req).
- reset_n pulsed low mid-beat1 of a store -> wren and be drop to 0 immediately, no done, busy=0.
- After release, a new req completes normally.
